// File: rtl/fifo_wr_arb_if.sv
// rtl/fifo_wr_arb_if.sv - requester/FIFO-side signal bundle for fifo_wr_arb
interface fifo_wr_arb_if #(
  parameter int NREQ = 4
) ();
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic              fifo_wren;
  logic [7:0]        fifo_data;
  logic              fifo_rd_ack;
  logic [5:0]        credits;

  modport master (
    output req, req_data, fifo_rd_ack,
    input  gnt, fifo_wren, fifo_data, credits
  );

  modport slave (
    input  req, req_data, fifo_rd_ack,
    output gnt, fifo_wren, fifo_data, credits
  );
endinterface

// File: rtl/fifo_wr_arb.sv
// rtl/fifo_wr_arb.sv - credit-based round-robin write arbiter; FIFO_WR_ARB_BURST_EN enables burst-lock
module fifo_wr_arb #(
  parameter int NREQ      = 4,
  parameter int DEPTH     = 31,
  parameter int BURST_MAX = 4
) (
  input logic          clk,
  input logic          rst,
  fifo_wr_arb_if.slave arb_if
);
  localparam int         PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [5:0] DEPTH_C = 6'(DEPTH);

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [5:0]       credits_q, credits_d;
  logic             fifo_wren_q;
  logic [7:0]       fifo_data_q, fifo_data_d;

  logic             win_found;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] sel_idx;
  logic             eligible;
  logic             accept;
  logic [NREQ-1:0]  gnt_vec;

`ifdef FIFO_WR_ARB_BURST_EN
  localparam int CNT_W = $clog2(BURST_MAX + 1);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] beat_q, beat_d;
`endif

  // Wrap-around successor of a requester index.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (int'(p) == NREQ - 1) return '0;
    return p + 1'b1;
  endfunction

  // Round-robin search: first requesting index at or after rr_ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_found && arb_if.req[(int'(rr_ptr_q) + k) % NREQ]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
  end

  // Accept decision and one-hot grant; a locked burst owner bypasses the search.
  always_comb begin
    sel_idx  = win_idx;
    eligible = win_found;
`ifdef FIFO_WR_ARB_BURST_EN
    if (state_q == ST_BURST) begin
      sel_idx  = owner_q;
      eligible = arb_if.req[owner_q];
    end
`endif
    accept  = !rst && (credits_q != 6'd0) && eligible;
    gnt_vec = '0;
    if (accept) gnt_vec[sel_idx] = 1'b1;
  end

  // Credit pool: accept consumes a slot, a pop returns one, saturating at DEPTH.
  always_comb begin
    credits_d = credits_q;
    if (accept && !arb_if.fifo_rd_ack) begin
      credits_d = credits_q - 6'd1;
    end else if (!accept && arb_if.fifo_rd_ack && (credits_q < DEPTH_C)) begin
      credits_d = credits_q + 6'd1;
    end
  end

  // Write data capture for the FIFO; holds between accepts.
  always_comb begin
    fifo_data_d = fifo_data_q;
    if (accept) fifo_data_d = arb_if.req_data[8*int'(sel_idx) +: 8];
  end

`ifdef FIFO_WR_ARB_BURST_EN
  // Burst-lock next state: lock onto a winner, release on request drop or beat limit.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    beat_d   = beat_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (BURST_MAX <= 1) begin
            rr_ptr_d = ptr_inc(win_idx);
          end else begin
            state_d = ST_BURST;
            owner_d = win_idx;
            beat_d  = CNT_W'(1);
          end
        end
      end
      ST_BURST: begin
        if (!arb_if.req[owner_q]) begin
          state_d  = ST_IDLE;
          rr_ptr_d = ptr_inc(owner_q);
          beat_d   = '0;
        end else if (accept) begin
          if (int'(beat_q) + 1 >= BURST_MAX) begin
            state_d  = ST_IDLE;
            rr_ptr_d = ptr_inc(owner_q);
            beat_d   = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Burst-lock state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      beat_q  <= beat_d;
    end
  end
`else
  // Per-beat rotation: the pointer moves just past each winner.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = ptr_inc(win_idx);
  end
`endif

  // Arbiter pointer, credit count and registered FIFO write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      credits_q   <= DEPTH_C;
      fifo_wren_q <= 1'b0;
      fifo_data_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      credits_q   <= credits_d;
      fifo_wren_q <= accept;
      fifo_data_q <= fifo_data_d;
    end
  end

  // Reset masks the outputs immediately so a word accepted just before reset never reaches the FIFO.
  assign arb_if.gnt       = gnt_vec;
  assign arb_if.fifo_wren = fifo_wren_q & ~rst;
  assign arb_if.fifo_data = rst ? 8'h00 : fifo_data_q;
  assign arb_if.credits   = rst ? DEPTH_C : credits_q;

endmodule
